// File: rtl/lsu_sequencer.sv
// lsu_sequencer
//   Load/store sequencer between the execute stage and a 32-bit word data bus.
//   Takes one byte/half/word access at a time, splits word-crossing accesses
//   into two aligned beats, generates lane write enables, and merges plus
//   sign-extends read data.
//
// Parameters
//   MISALIGNED_EN  1: split word-crossing accesses into two beats; 0: fault them
//   TIMEOUT        max wait cycles per beat (8-bit counter); 0 disables timeout
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req, i_we, i_addr, i_length, access request (sampled when not busy):
//   i_signed_rd, i_data_wr           store/load, byte address, size, sign, data
//   o_busy                         access in progress, new requests dropped
//   o_done, o_fault                one-cycle completion pulse and its fault flag
//   o_data_rd                      load result, held until the next o_done
//   o_bus_valid, o_bus_addr,       bus beat request, word address,
//   o_bus_we, o_bus_data_wr          lane write enables, lane-placed store data
//   i_bus_ready, i_bus_data_rd     beat completion and read word
module lsu_sequencer #(
  parameter bit          MISALIGNED_EN = 1'b1,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_length,
  input  logic        i_signed_rd,
  input  logic [31:0] i_data_wr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_data_rd,
  output logic        o_bus_valid,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_we,
  output logic [31:0] o_bus_data_wr,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_data_rd
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // Lane mask over two consecutive words: bits [3:0] first word, [7:4] second.
  function automatic logic [7:0] lane_mask(input logic [1:0] len, input logic [1:0] s);
    logic [7:0] m;
    case (len)
      2'd0:    m = 8'b0000_0001;
      2'd1:    m = 8'b0000_0011;
      default: m = 8'b0000_1111;
    endcase
    return m << s;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return d;
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[7:0],  d[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return d;
      2'd1:    return {d[7:0],  d[31:8]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[23:0], d[31:24]};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  s_q, len_q;
  logic        we_q, sgn_q, fault_q;
  logic [7:0]  cnt_q;
  logic [31:0] merge_q, merge_d, aligned, load_res;
  logic [7:0]  in_mask, q_mask;
  logic [3:0]  beat_lanes;
  logic        accept, in_bad, q_cross, timed_out;

  assign accept    = i_req && (state_q == IDLE || state_q == RESP);
  assign in_mask   = lane_mask(i_length, i_addr[1:0]);
  assign in_bad    = (i_length == 2'd3) || (!MISALIGNED_EN && (in_mask[7:4] != 4'b0000));
  assign q_mask    = lane_mask(len_q, s_q);
  assign q_cross   = (q_mask[7:4] != 4'b0000);
  assign timed_out = TO_EN && !i_bus_ready && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) state_d = in_bad ? RESP : BEAT0;
        else        state_d = IDLE;
      end
      BEAT0: begin
        if (i_bus_ready)    state_d = q_cross ? BEAT1 : RESP;
        else if (timed_out) state_d = RESP;
      end
      BEAT1: begin
        if (i_bus_ready || timed_out) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the state register
  always_comb begin
    o_busy      = (state_q == BEAT0) || (state_q == BEAT1);
    o_bus_valid = o_busy;
    o_done      = (state_q == RESP);
    o_fault     = (state_q == RESP) && fault_q;
  end

  // Read merge: the current beat's lanes overwrite the merge register.
  always_comb begin
    beat_lanes = (state_q == BEAT1) ? q_mask[7:4] : q_mask[3:0];
    merge_d    = merge_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (beat_lanes[i]) merge_d[8*i +: 8] = i_bus_data_rd[8*i +: 8];
    end
  end

  always_comb begin
    aligned = rotr32(merge_d, s_q);
    case (len_q)
      2'd0:    load_res = {{24{sgn_q & aligned[7]}},  aligned[7:0]};
      2'd1:    load_res = {{16{sgn_q & aligned[15]}}, aligned[15:0]};
      default: load_res = aligned;
    endcase
  end

  // Datapath: request latch, bus beat registers, timeout counter, load result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q           <= '0;
      len_q         <= '0;
      we_q          <= 1'b0;
      sgn_q         <= 1'b0;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
      merge_q       <= '0;
      o_data_rd     <= '0;
      o_bus_addr    <= '0;
      o_bus_we      <= '0;
      o_bus_data_wr <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            s_q     <= i_addr[1:0];
            len_q   <= i_length;
            we_q    <= i_we;
            sgn_q   <= i_signed_rd;
            fault_q <= in_bad;
            cnt_q   <= '0;
            if (!in_bad) begin
              o_bus_addr    <= {i_addr[31:2], 2'b00};
              o_bus_we      <= i_we ? in_mask[3:0] : 4'b0000;
              o_bus_data_wr <= rotl32(i_data_wr, i_addr[1:0]);
            end
          end
        end
        BEAT0, BEAT1: begin
          if (i_bus_ready) begin
            merge_q <= merge_d;
            cnt_q   <= '0;
            if (state_d == BEAT1) begin
              // Second word wraps naturally from 0xFFFFFFFC to 0.
              o_bus_addr <= o_bus_addr + 32'd4;
              o_bus_we   <= we_q ? q_mask[7:4] : 4'b0000;
            end else if (!we_q) begin
              o_data_rd <= load_res;
            end
          end else if (timed_out) begin
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, sgn;
  logic [31:0] addr, wdata;
  logic [1:0]  len;
  logic        busy, done, fault;
  logic [31:0] data_rd;
  logic        bus_valid;
  logic [31:0] bus_addr, bus_wd;
  logic [3:0]  bus_we;
  logic        bus_ready;
  logic [31:0] bus_rd;

  // Second instance: misaligned splitting disabled, always-ready bus.
  logic        b_req, b_we, b_sgn;
  logic [31:0] b_addr, b_wdata;
  logic [1:0]  b_len;
  logic        b_busy, b_done, b_fault;
  logic [31:0] b_data_rd;
  logic        b_bus_valid;
  logic [31:0] b_bus_addr, b_bus_wd;
  logic [3:0]  b_bus_we;
  logic        b_bus_ready;
  logic [31:0] b_bus_rd;

  lsu_sequencer #(.MISALIGNED_EN(1'b1), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_length(len), .i_signed_rd(sgn), .i_data_wr(wdata),
    .o_busy(busy), .o_done(done), .o_fault(fault), .o_data_rd(data_rd),
    .o_bus_valid(bus_valid), .o_bus_addr(bus_addr), .o_bus_we(bus_we),
    .o_bus_data_wr(bus_wd), .i_bus_ready(bus_ready), .i_bus_data_rd(bus_rd)
  );

  lsu_sequencer #(.MISALIGNED_EN(1'b0), .TIMEOUT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_we(b_we), .i_addr(b_addr),
    .i_length(b_len), .i_signed_rd(b_sgn), .i_data_wr(b_wdata),
    .o_busy(b_busy), .o_done(b_done), .o_fault(b_fault), .o_data_rd(b_data_rd),
    .o_bus_valid(b_bus_valid), .o_bus_addr(b_bus_addr), .o_bus_we(b_bus_we),
    .o_bus_data_wr(b_bus_wd), .i_bus_ready(b_bus_ready), .i_bus_data_rd(b_bus_rd)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    bit          is_store;
    int          waits;   // -1: never ready
  } beat_t;

  typedef struct {
    bit          fault;
    logic [31:0] data;
    int unsigned cyc;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  // Bus memory: explicit overrides, otherwise a hash of the word address.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] word_at(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] last_rd = '0;

  // Reference model: works byte by byte over the address range of the access.
  // Cycle numbers: an access accepted at posedge number acc shows o_done at
  // the negedge following posedge acc + sum(1 + waits) over its beats.
  task automatic issue(input bit w, input logic [31:0] a, input logic [1:0] l,
                       input bit sg, input logic [31:0] d, input bit hang,
                       input bit zero_wait);
    resp_t       r;
    int          nb, nbeats;
    int unsigned lat;
    logic [31:0] first, last, res, ba, wb;
    bit          faulted_now;
    r.fault = 1'b0;
    r.data  = last_rd;
    lat     = 0;
    faulted_now = 1'b0;
    if (l == 2'd3) begin
      r.fault = 1'b1;
      faulted_now = 1'b1;
    end else begin
      nb     = (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
      first  = a & ~32'd3;
      last   = (a + 32'(nb - 1)) & ~32'd3;
      nbeats = (first != last) ? 2 : 1;
      for (int b = 0; b < nbeats; b++) begin
        beat_t bt;
        bt.addr     = (b == 0) ? first : last;
        bt.we       = 4'b0000;
        bt.is_store = w;
        for (int k = 0; k < nb; k++) begin
          ba = a + 32'(k);
          if (w && ((ba & ~32'd3) == bt.addr)) bt.we[ba[1:0]] = 1'b1;
        end
        for (int ln = 0; ln < 4; ln++)
          bt.data[8*ln +: 8] = d[8*((ln - int'(a[1:0])) & 3) +: 8];
        if (hang) begin
          bt.waits = -1;
          beat_q.push_back(bt);
          r.fault = 1'b1;
          lat = TO;
          break;
        end
        bt.waits = zero_wait ? 0 : int'($urandom_range(0, 3));
        lat += 32'(1 + bt.waits);
        beat_q.push_back(bt);
      end
      if (!w && !hang) begin
        res = '0;
        for (int k = 0; k < nb; k++) begin
          ba = a + 32'(k);
          wb = word_at(ba & ~32'd3);
          res[8*k +: 8] = wb[8*ba[1:0] +: 8];
        end
        if (sg && res[8*nb-1])
          for (int k = nb; k < 4; k++) res[8*k +: 8] = 8'hFF;
        r.data  = res;
        last_rd = res;
      end
    end
    r.cyc = cyc + 1 + lat;
    resp_q.push_back(r);
    req = 1'b1; we = w; addr = a; len = l; sgn = sg; wdata = d;
    @(negedge clk);
    // A request while busy must be dropped.
    if (!faulted_now && busy === 1'b1 && $urandom_range(0, 1) == 1) begin
      req = 1'b1; we = 1'($urandom); addr = $urandom; len = 2'($urandom);
      wdata = $urandom;
    end else begin
      req = 1'b0;
    end
    for (int t = 0; t < 60 && done !== 1'b1; t++) begin
      @(negedge clk);
      req = 1'b0;
    end
    req = 1'b0;
    if (done !== 1'b1) check32("done_wait_expired", 32'(done), 32'd1);
  endtask

  // Monitor: pops the expected response whenever o_done is presented.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && done === 1'b1) begin
        if (resp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: o_done=1 with no access outstanding (cycle %0d)", cyc);
        end else begin
          r = resp_q.pop_front();
          check32("done_fault", 32'(fault), 32'(r.fault));
          check32("data_rd", data_rd, r.data);
          check32("done_cycle", cyc, r.cyc);
          check32("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Bus responder: checks each beat against the expected beat queue.
  initial begin
    beat_t cur;
    bit    in_beat = 1'b0;
    int    wcnt = 0;
    bus_ready = 1'b0;
    bus_rd    = '0;
    cur.waits = 0; cur.addr = '0; cur.we = '0; cur.data = '0; cur.is_store = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_ready = 1'b0;
        in_beat   = 1'b0;
      end else if (bus_valid === 1'b1) begin
        if (!in_beat) begin
          if (beat_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: addr %h we %b, no beat expected", bus_addr, bus_we);
            cur.addr = bus_addr; cur.we = bus_we; cur.data = bus_wd;
            cur.is_store = 1'b0; cur.waits = 0;
          end else begin
            cur = beat_q.pop_front();
          end
          in_beat = 1'b1;
          wcnt    = 0;
          check32("beat_addr", bus_addr, cur.addr);
          check32("beat_we", 32'(bus_we), 32'(cur.we));
          if (cur.is_store) check32("beat_data", bus_wd, cur.data);
        end else begin
          check32("hold_addr", bus_addr, cur.addr);
          check32("hold_we", 32'(bus_we), 32'(cur.we));
        end
        if (cur.waits >= 0 && wcnt == cur.waits) begin
          bus_ready = 1'b1;
          bus_rd    = word_at(cur.addr);
          in_beat   = 1'b0;
        end else begin
          bus_ready = 1'b0;
          bus_rd    = $urandom;
          wcnt++;
        end
      end else begin
        in_beat   = 1'b0;
        bus_ready = ($urandom_range(0, 3) == 0);  // stray ready must be ignored
        bus_rd    = $urandom;
      end
    end
  end

  task automatic random_access();
    logic [31:0] a;
    logic [1:0]  l;
    a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
    l = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    issue(1'($urandom), a, l, 1'($urandom), $urandom,
          $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
  endtask

  initial begin
    req = 0; we = 0; sgn = 0; addr = '0; wdata = '0; len = '0;
    b_req = 0; b_we = 0; b_sgn = 0; b_addr = '0; b_wdata = '0; b_len = '0;
    b_bus_ready = 1'b1; b_bus_rd = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done_fault", {30'd0, done, fault}, 32'd0);
    check32("rst_bus_valid", 32'(bus_valid), 32'd0);
    check32("rst_data_rd", data_rd, 32'd0);
    check32("rst_bus_addr", bus_addr, 32'd0);
    check32("rst_bus_we_data", bus_wd | 32'(bus_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[32'h100] = 32'hDEAD_BEEF;
    issue(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'h203, 2'd0, 1'b0, 32'h0000_00A5, 1'b0, 1'b1);
    mem[32'h104] = 32'h8012_3456; mem[32'h108] = 32'h6543_217F;
    issue(1'b0, 32'h107, 2'd1, 1'b1, 32'h0, 1'b0, 1'b1);
    mem[32'h104] = 32'hFF00_0000; mem[32'h108] = 32'h0000_0080;
    issue(1'b0, 32'h107, 2'd1, 1'b1, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h1122_3344, 1'b0, 1'b1);
    issue(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h400, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) random_access();

    // Reset in the middle of a waiting second beat.
    @(negedge clk);
    begin
      beat_t b0, b1;
      b0.addr = 32'h1FC; b0.we = '0; b0.data = '0; b0.is_store = 1'b0; b0.waits = 0;
      b1.addr = 32'h200; b1.we = '0; b1.data = '0; b1.is_store = 1'b0; b1.waits = -1;
      beat_q.push_back(b0);
      beat_q.push_back(b1);
    end
    req = 1'b1; we = 1'b0; addr = 32'h1FF; len = 2'd1; sgn = 1'b0;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check32("beat1_waiting_valid", 32'(bus_valid), 32'd1);
    check32("beat1_waiting_addr", bus_addr, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    check32("async_rst_valid", 32'(bus_valid), 32'd0);
    check32("async_rst_busy", 32'(busy), 32'd0);
    check32("async_rst_done", 32'(done), 32'd0);
    check32("beats_consumed", 32'(beat_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) random_access();

    // Instance with splitting disabled.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'hFFFF_FFFE; b_len = 2'd2; b_wdata = 32'h1122_3344;
    @(negedge clk);
    b_req = 1'b0;
    check32("noms_cross_fault", {30'd0, b_done, b_fault}, 32'd3);
    check32("noms_cross_no_beat", 32'(b_bus_valid), 32'd0);
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h100; b_len = 2'd2; b_sgn = 1'b0;
    @(negedge clk);
    b_req = 1'b0;
    check32("noms_word_beat_addr", b_bus_addr, 32'h100);
    check32("noms_word_valid", {30'd0, b_bus_valid, b_done}, 32'd2);
    @(negedge clk);
    check32("noms_word_done", {30'd0, b_done, b_fault}, 32'd2);
    check32("noms_word_data", b_data_rd, 32'hCAFE_F00D);
    b_req = 1'b1; b_addr = 32'h106; b_len = 2'd1; b_sgn = 1'b1;
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk);
    check32("noms_half_done", {30'd0, b_done, b_fault}, 32'd2);
    check32("noms_half_data", b_data_rd, 32'hFFFF_CAFE);
    b_req = 1'b1; b_addr = 32'h107;
    @(negedge clk);
    b_req = 1'b0;
    check32("noms_half_cross_fault", {30'd0, b_done, b_fault}, 32'd3);
    check32("noms_fault_keeps_data", b_data_rd, 32'hFFFF_CAFE);

    repeat (3) @(negedge clk);
    check32("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
